// File: rtl/axi_rd_decoder_n.sv
// rtl/axi_rd_decoder_n.sv - AXI4-Lite read-channel decoder, one master to NUM_SLAVES slaves, in-order R return
// Optional macro AXI_RD_DEC_DECERR_EN: unmapped reads get an internal DECERR beat instead of going to slave 0.
module axi_rd_decoder_n #(
  parameter int NUM_SLAVES = 2,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_OUTST  = 4,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h0010_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hFFF0_0000, 32'hFFF0_0000}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            s_araddr,
  input  logic                         s_arvalid,
  output logic                         s_arready,
  output logic [DATA_W-1:0]            s_rdata,
  output logic [1:0]                   s_rresp,
  output logic                         s_rvalid,
  input  logic                         s_rready,
  output logic [NUM_SLAVES*ADDR_W-1:0] m_araddr,
  output logic [NUM_SLAVES-1:0]        m_arvalid,
  input  logic [NUM_SLAVES-1:0]        m_arready,
  input  logic [NUM_SLAVES*DATA_W-1:0] m_rdata,
  input  logic [NUM_SLAVES*2-1:0]      m_rresp,
  input  logic [NUM_SLAVES-1:0]        m_rvalid,
  output logic [NUM_SLAVES-1:0]        m_rready
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam int PTR_W = $clog2(MAX_OUTST);
`ifdef AXI_RD_DEC_DECERR_EN
  localparam int TOK_W = $clog2(NUM_SLAVES + 1);
  localparam logic [TOK_W-1:0] DEC_TOK = TOK_W'(NUM_SLAVES);
`else
  localparam int TOK_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
`endif

  logic             hit;
  logic [TOK_W-1:0] sel;
  logic [TOK_W-1:0] push_tok;
  logic             fwd;
  logic             tgt_ready;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [TOK_W-1:0] head;

  logic [TOK_W-1:0] fifo_q [MAX_OUTST];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  assign m_araddr = {NUM_SLAVES{s_araddr}};

  // Descending scan so the lowest matching index is the one left in sel.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((s_araddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        sel = TOK_W'(i);
      end
    end
  end

`ifdef AXI_RD_DEC_DECERR_EN
  assign push_tok = hit ? sel : DEC_TOK;
  assign fwd      = hit;
`else
  assign push_tok = hit ? sel : '0;
  assign fwd      = 1'b1;
`endif

  assign full  = (count == CNT_W'(MAX_OUTST));
  assign empty = (count == '0);
  assign head  = fifo_q[rd_ptr];

  always_comb begin
    tgt_ready = 1'b0;
    m_arvalid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (push_tok == TOK_W'(i)) begin
        tgt_ready    = m_arready[i];
        m_arvalid[i] = s_arvalid & fwd & ~full & ~rst;
      end
    end
  end

  // A miss with the internal responder needs no slave handshake.
  assign s_arready = ~rst & ~full & (fwd ? tgt_ready : 1'b1);
  assign push      = s_arvalid & s_arready;
  assign pop       = s_rvalid & s_rready;

  always_comb begin
    s_rvalid = 1'b0;
    s_rdata  = '0;
    s_rresp  = '0;
    m_rready = '0;
    if (!rst && !empty) begin
      for (int i = 0; i < NUM_SLAVES; i++) begin
        if (head == TOK_W'(i)) begin
          s_rvalid    = m_rvalid[i];
          s_rdata     = m_rdata[i*DATA_W +: DATA_W];
          s_rresp     = m_rresp[i*2 +: 2];
          m_rready[i] = s_rready;
        end
      end
`ifdef AXI_RD_DEC_DECERR_EN
      if (head == DEC_TOK) begin
        s_rvalid = 1'b1;
        s_rresp  = 2'b11;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= push_tok;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/axi_rd_decoder_n.md
# axi_rd_decoder_n

Parametrised AXI4-Lite read-channel decoder connecting one read master (the CPU instruction port) to NUM_SLAVES read slaves such as Boot ROM and IRAM. It decodes each AR address against a per-slave base/mask map and tracks up to MAX_OUTST outstanding reads in a routing FIFO. R beats are returned strictly in issue order, even when slaves respond out of order relative to each other. Unmapped addresses get an internally generated decode-error response.

## Interface
- NUM_SLAVES, 2: number of downstream read slaves (1..8).
- ADDR_W, 32: address width.
- DATA_W, 32: read data width.
- MAX_OUTST, 4: routing FIFO depth; power of two, ≥2.
- SLV_BASE, {32'h0010_0000, 32'h0000_0000}: packed NUM_SLAVES×ADDR_W base addresses; slice i belongs to slave i (slave 0 = ROM, slave 1 = IRAM).
- SLV_MASK, {32'hFFF0_0000, 32'hFFF0_0000}: packed NUM_SLAVES×ADDR_W compare masks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset. One clock; reset is asynchronous and active-high.
- s_araddr  in  ADDR_W  master read address.
- s_arvalid  in  1 / s_arready  out  1: master AR handshake.
- s_rdata  out  DATA_W  read data to master.
- s_rresp  out  2  read response to master.
- s_rvalid  out  1 / s_rready  in  1: master R handshake.
- m_araddr  out  NUM_SLAVES×ADDR_W  per-slave address; every slice carries s_araddr.
- m_arvalid  out  NUM_SLAVES / m_arready  in  NUM_SLAVES: per-slave AR handshake.
- m_rdata  in  NUM_SLAVES×DATA_W  per-slave read data.
- m_rresp  in  NUM_SLAVES×2  per-slave read response.
- m_rvalid  in  NUM_SLAVES / m_rready  out  NUM_SLAVES: per-slave R handshake.

## Operation
- Decode: slave i matches when (s_araddr & SLV_MASK[i]) == SLV_BASE[i]. If several slaves match, the lowest index wins. No match means a miss.
- AR forwarding:
  - m_arvalid[i] = s_arvalid & sel_i & !full.
  - s_arready = !full & (hit ? m_arready[sel] : 1).
- On an AR handshake, push a target token into the routing FIFO: the slave index, or the DECERR token (value NUM_SLAVES) on a miss. Token width is clog2(NUM_SLAVES+1).
- Only single-beat reads are supported. There is no burst or ID support.
- R routing: when the FIFO is non-empty, the head token h selects the response source.
  - s_rvalid = m_rvalid[h]; s_rdata and s_rresp come from slice h.
  - m_rready[h] = s_rready. All other m_rready bits are 0.
  - A slave asserting rvalid while it is not at the head is held; it must keep rvalid and data stable.
- Decode-error head: s_rvalid=1, s_rdata=0, s_rresp=2'b11 (DECERR). No slave is touched.
- Pop the FIFO on s_rvalid & s_rready.
- FIFO state: write pointer, read pointer, and a count of width clog2(MAX_OUTST+1).
  - full = (count == MAX_OUTST); empty = (count == 0).
  - A push and a pop in the same cycle leave count unchanged.
- Full: AR is blocked even if a pop occurs in the same cycle. The full flag is evaluated on registered count.
- Empty: s_rvalid=0 and all m_rready=0, regardless of slave rvalid.

## Timing
- AR path is combinational: decode to m_arvalid and s_arready within the same cycle. This adds zero added latency.
- The routing token becomes visible at the FIFO head on the clock edge after the AR handshake.
  - A slave rvalid asserted in the same cycle as its AR handshake is therefore not forwarded until the next cycle.
  - The earliest DECERR response appears 1 cycle after the AR handshake.
- The R path is combinational from the registered head token.
- Maximum throughput is one read per cycle while the FIFO is not full and slaves are ready.
- Reset (rst=1, any time):
  - Pointers and count clear asynchronously.
  - While rst=1: s_arready=0, all m_arvalid=0, s_rvalid=0, all m_rready=0, s_rdata=0, s_rresp=0.
- Outstanding reads are discarded on reset. Slaves must share the same reset.

## Configuration
- AXI_RD_DEC_DECERR_EN defined: misses behave as described above. The DECERR token is pushed and a 2'b11 response is generated internally.
- AXI_RD_DEC_DECERR_EN undefined: misses are routed to slave 0 (default slave), and the token is 0. There is no internal responder, and the token width is clog2(NUM_SLAVES).

## Test plan
- ROM read: AR at 0x0000_0040; slave 0 returns 0xDEAD_BEEF with rresp=0 one cycle later. Required: s_rdata=0xDEAD_BEEF, s_rresp=0, and m_arvalid[1] never asserts.
- Ordering: back-to-back ARs to 0x0010_0000 (IRAM) then 0x0000_0000 (ROM). ROM asserts rvalid first. Required: the IRAM beat is delivered first, and m_rready[0] stays 0 until the IRAM pop.
- Full stall: with MAX_OUTST=4, issue 4 ARs with s_rready=0. Required: the 5th AR sees s_arready=0. After one R pop, s_arready rises in the next cycle.
- Decode error (macro on): AR at 0x8000_0000. Required: no m_arvalid. The next cycle shows s_rvalid=1, s_rdata=0, s_rresp=2'b11. With the macro off, slave 0 receives the AR.
- Backpressure: slave 1 asserts rvalid while s_rready=0 for 3 cycles. Required: s_rvalid is held with stable data, and the pop occurs only on the cycle s_rready=1.
- Reset mid-operation: assert rst with 3 reads outstanding. Required: s_rvalid=0 and s_arready=0 immediately (asynchronously). After release, count=0 and a new AR completes normally.
